// File: rtl/ram256x64_sync.sv
// ram256x64_sync
//   Single-port 256 x 64-bit load/store RAM for the processor datapath.
//   One shared address bus for reads and writes, one write enable, registered read data.
//   Storage is a resettable flop array so that reset can clear every word at once.
//
// Ports
//   clock     in   1       system clock; all state updates on the rising edge
//   reset_n   in   1       asynchronous reset, active low; clears storage and out
//   address   in   ADDR_W  word address (every value is a distinct word)
//   in        in   DATA_W  write data
//   ramWrite  in   1       write enable, active high
//   out       out  DATA_W  registered read data (new data on a write)

// One storage word: loads wr_data on an enabled edge, otherwise holds.
module ram256x64_word #(
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (wr_en)
            q_d = wr_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

module ram256x64_sync #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    input  logic              ramWrite,
    output logic [DATA_W-1:0] out
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]  word_we;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] out_d;
    logic [DATA_W-1:0] out_q;

    // Per-word write decode: exactly one word is enabled on a write.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        assign word_we[g] = ramWrite && (address == ADDR_W'(g));

        ram256x64_word #(
            .DATA_W (DATA_W)
        ) u_word (
            .clock   (clock),
            .reset_n (reset_n),
            .wr_en   (word_we[g]),
            .wr_data (in),
            .q       (mem_q[g])
        );
    end

    // Read mux feeds a register, so there is no combinational address->out path.
    // On a write the incoming word is forwarded (write-through / new data).
    always_comb begin
        out_d = mem_q[address];
        if (ramWrite)
            out_d = in;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            out_q <= '0;
        else
            out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_ram256x64_sync.sv
// tb_ram256x64_sync
//   Directed checks for ram256x64_sync: reset, readback, write-through,
//   full-range sweep with wrap, word isolation and reset after fill.
module tb_ram256x64_sync;

    logic        clock;
    logic        reset_n;
    logic [7:0]  address;
    logic [63:0] din;
    logic        ramWrite;
    logic [63:0] dout;

    logic [63:0] model [256];
    logic [63:0] wdata;
    logic [63:0] held;
    int          n_assert;
    int          n_fail;

    ram256x64_sync dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .address  (address),
        .in       (din),
        .ramWrite (ramWrite),
        .out      (dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] d);
        address  = a;
        din      = d;
        ramWrite = 1'b1;
        cyc();
        ramWrite = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        address  = a;
        ramWrite = 1'b0;
        cyc();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        address  = '0;
        din      = '0;
        ramWrite = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = '0;

        #2;
        check("reset_out_initial", dout, 64'h0);
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();

        // 1. Mid-cycle reset pulse after placing data at 0, 128, 255.
        wr(8'h00, 64'h1111_2222_3333_4444);
        wr(8'h80, 64'h5555_6666_7777_8888);
        wr(8'hFF, 64'h9999_AAAA_BBBB_CCCC);
        check("pre_reset_out_wt", dout, 64'h9999_AAAA_BBBB_CCCC);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_async_out", dout, 64'h0);
        // A write presented across an edge during reset must be ignored.
        address  = 8'h07;
        din      = 64'hFFFF_0000_FFFF_0000;
        ramWrite = 1'b1;
        cyc();
        check("reset_hold_out", dout, 64'h0);
        ramWrite = 1'b0;
        #2;
        reset_n = 1'b1;
        rd(8'h00);   check("reset_rd_00", dout, 64'h0);
        rd(8'h80);   check("reset_rd_80", dout, 64'h0);
        rd(8'hFF);   check("reset_rd_FF", dout, 64'h0);
        rd(8'h07);   check("reset_wr_ignored", dout, 64'h0);

        // 2. Write then read back with one-cycle latency.
        wr(8'h05, 64'hDEADBEEF_01234567);
        model[5] = 64'hDEADBEEF_01234567;
        rd(8'h00);   check("readback_other", dout, 64'h0);
        rd(8'h05);   check("readback_05", dout, 64'hDEADBEEF_01234567);
        // Out holds between edges even when the address moves.
        address = 8'h00;
        #3;
        check("out_holds", dout, 64'hDEADBEEF_01234567);

        // 3. Write-through: new data on out after the same edge.
        wr(8'h10, 64'hA5A5_A5A5_A5A5_A5A5);
        check("write_through", dout, 64'hA5A5_A5A5_A5A5_A5A5);
        rd(8'h10);   check("write_through_rb", dout, 64'hA5A5_A5A5_A5A5_A5A5);

        // 4. Sweep 300 writes with wrap 255->0, then read all 256 words.
        address  = 8'h00;
        ramWrite = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wdata = {$urandom, $urandom};
            din   = wdata;
            model[address] = wdata;
            cyc();
            if (i % 64 == 0) check("sweep_wt", dout, wdata);
            address = address + 8'd1;
        end
        ramWrite = 1'b0;
        for (int a = 0; a < 256; a++) begin
            rd(8'(a));
            check($sformatf("sweep_rd_%02h", a), dout, model[a]);
        end

        // 5. Isolation at the top/bottom boundary.
        wr(8'hFE, 64'h3);
        wr(8'hFF, 64'h1);
        wr(8'h00, 64'h2);
        rd(8'hFF);   check("iso_FF", dout, 64'h1);
        rd(8'h00);   check("iso_00", dout, 64'h2);
        rd(8'hFE);   check("iso_FE", dout, 64'h3);
        rd(8'h01);   check("iso_01", dout, model[1]);

        // 6. Fill everything, reset, confirm all words cleared.
        for (int a = 0; a < 256; a++) wr(8'(a), {32'hC0DE_0000 | 32'(a), 32'(~a)});
        rd(8'h2A);   check("fill_rd_2A", dout, {32'hC0DE_002A, ~32'h2A});
        held = dout;
        #2;
        reset_n = 1'b0;
        #1;
        check("fill_reset_out", dout, 64'h0);
        cyc();
        check("fill_reset_out_edge", dout, 64'h0);
        #2;
        reset_n = 1'b1;
        for (int a = 0; a < 256; a++) begin
            rd(8'(a));
            check($sformatf("fill_clr_%02h", a), dout, 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
